// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_core
//  Description : MM:SS BCD stopwatch with run/pause/adjust FSM and a
//                4-digit multiplexed active-low 7-segment display driver.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_core #(
    parameter int MAX_MIN  = 59,
    parameter bit BLINK_EN = 1'b1
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       clk_4hz,
    input  logic       clk_500hz,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_adjust,
    input  logic       sw_sel,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] state,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [3:0] C_MAX_MIN_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] C_MAX_MIN_O = 4'(MAX_MIN % 10);
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSE  = 2'b01,
        ST_ADJUST = 2'b10
    } state_t;

    state_t     state_q, state_d, state_tmp;
    logic       run_flag_q, run_flag_d;
    logic       blink_q, blink_d;
    logic       btn_pause_q, btn_clr_q;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic [3:0] digit;
    logic       blank;
    logic       pause_evt, clr_evt;

    function automatic logic [7:0] sec_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) begin
            if (v[7:4] >= 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] v);
        if (v >= {C_MAX_MIN_T, C_MAX_MIN_O}) return 8'h00;
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return C_SEG_BLANK;
        endcase
    endfunction

    assign pause_evt = btn_pause & ~btn_pause_q;
    assign clr_evt   = btn_clr & ~btn_clr_q;

    // FSM: in RUN/PAUSE a same-cycle pause toggle is resolved before the
    // run flag is captured on entry to ADJUST.
    always_comb begin
        state_d    = state_q;
        state_tmp  = state_q;
        run_flag_d = run_flag_q;
        case (state_q)
            ST_RUN, ST_PAUSE: begin
                if (pause_evt)
                    state_tmp = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
                if (sw_adjust) begin
                    state_d    = ST_ADJUST;
                    run_flag_d = (state_tmp == ST_RUN);
                end else begin
                    state_d = state_tmp;
                end
            end
            ST_ADJUST: begin
                if (pause_evt)
                    run_flag_d = ~run_flag_q;
                if (!sw_adjust)
                    state_d = run_flag_d ? ST_RUN : ST_PAUSE;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        blink_d = 1'b0;
        if (state_q == ST_ADJUST && state_d == ST_ADJUST)
            blink_d = clk_4hz ? ~blink_q : blink_q;
    end

    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (clr_evt) begin
            min_d = 8'h00;
            sec_d = 8'h00;
        end else if (state_q == ST_RUN && clk_1hz) begin
            sec_d = sec_inc(sec_q);
            if (sec_d == 8'h00)
                min_d = min_inc(min_q);
        end else if (state_q == ST_ADJUST && clk_2hz) begin
            if (sw_sel)
                sec_d = sec_inc(sec_q);
            else
                min_d = min_inc(min_q);
        end
    end

    // Display refreshes only on scan ticks, so time changes show up at the
    // next visit of the affected digit.
    always_comb begin
        idx_d = idx_q;
        an_d  = an_q;
        seg_d = seg_q;
        digit = 4'd0;
        blank = 1'b0;
        if (clk_500hz) begin
            idx_d = idx_q + 2'd1;
            an_d  = ~(4'b0001 << idx_d);
            case (idx_d)
                2'd0:    digit = sec_q[3:0];
                2'd1:    digit = sec_q[7:4];
                2'd2:    digit = min_q[3:0];
                default: digit = min_q[7:4];
            endcase
            blank = BLINK_EN && (state_q == ST_ADJUST) && blink_q &&
                    (sw_sel ? (idx_d < 2'd2) : (idx_d >= 2'd2));
            seg_d = blank ? C_SEG_BLANK : seg_of(digit);
        end
    end

    always_ff @(posedge clk_100mhz) begin
        // Edge registers track the buttons even in reset so a held button
        // cannot fire once reset releases.
        btn_pause_q <= btn_pause;
        btn_clr_q   <= btn_clr;
        if (!rst_n) begin
            state_q    <= ST_RUN;
            run_flag_q <= 1'b1;
            blink_q    <= 1'b0;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            seg_q      <= 7'b1000000;
        end else begin
            state_q    <= state_d;
            run_flag_q <= run_flag_d;
            blink_q    <= blink_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign state   = state_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_core
//  Description : Scoreboard bench for stopwatch_core (MAX_MIN=59 blinking
//                instance plus a MAX_MIN=9 non-blinking instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_1hz = 1'b0, clk_2hz = 1'b0, clk_4hz = 1'b0, clk_500hz = 1'b0;
    logic btn_pause = 1'b0, btn_clr = 1'b0, sw_adjust = 1'b0, sw_sel = 1'b0;

    logic [7:0] min_a, sec_a, min_b, sec_b;
    logic [1:0] st_a, st_b;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.MAX_MIN(59), .BLINK_EN(1'b1)) dut (
        .clk_100mhz(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .clk_2hz(clk_2hz),
        .clk_4hz(clk_4hz), .clk_500hz(clk_500hz), .btn_pause(btn_pause),
        .btn_clr(btn_clr), .sw_adjust(sw_adjust), .sw_sel(sw_sel),
        .min_bcd(min_a), .sec_bcd(sec_a), .state(st_a), .an(an_a), .seg(seg_a)
    );

    stopwatch_core #(.MAX_MIN(9), .BLINK_EN(1'b0)) dut9 (
        .clk_100mhz(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .clk_2hz(clk_2hz),
        .clk_4hz(clk_4hz), .clk_500hz(clk_500hz), .btn_pause(btn_pause),
        .btn_clr(btn_clr), .sw_adjust(sw_adjust), .sw_sel(sw_sel),
        .min_bcd(min_b), .sec_bcd(sec_b), .state(st_b), .an(an_b), .seg(seg_b)
    );

    typedef struct {
        string      name;
        bit         which;
        bit         disp;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [1:0] st;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;

    task automatic cmp(input string name, input string fld,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, fld, act, req);
        end
    endtask

    // Monitor: compares every queued expectation against the outputs
    // presented after the last active edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            if (!e_mon.which) begin
                cmp(e_mon.name, "min", min_a, e_mon.mn);
                cmp(e_mon.name, "sec", sec_a, e_mon.sc);
                cmp(e_mon.name, "state", {6'd0, st_a}, {6'd0, e_mon.st});
                if (e_mon.disp) begin
                    cmp(e_mon.name, "an", {4'd0, an_a}, {4'd0, e_mon.an});
                    cmp(e_mon.name, "seg", {1'b0, seg_a}, {1'b0, e_mon.seg});
                end
            end else begin
                cmp(e_mon.name, "min9", min_b, e_mon.mn);
                cmp(e_mon.name, "sec9", sec_b, e_mon.sc);
                cmp(e_mon.name, "state9", {6'd0, st_b}, {6'd0, e_mon.st});
                if (e_mon.disp) begin
                    cmp(e_mon.name, "an9", {4'd0, an_b}, {4'd0, e_mon.an});
                    cmp(e_mon.name, "seg9", {1'b0, seg_b}, {1'b0, e_mon.seg});
                end
            end
        end
    end

    task automatic expect_t(input string name, input bit which,
                            input logic [7:0] mn, input logic [7:0] sc,
                            input logic [1:0] st);
        exp_t e;
        e.name = name; e.which = which; e.disp = 1'b0;
        e.mn = mn; e.sc = sc; e.st = st; e.an = 4'h0; e.seg = 7'h0;
        exp_q.push_back(e);
    endtask

    task automatic expect_d(input string name, input bit which,
                            input logic [7:0] mn, input logic [7:0] sc,
                            input logic [1:0] st, input logic [3:0] a,
                            input logic [6:0] s);
        exp_t e;
        e.name = name; e.which = which; e.disp = 1'b1;
        e.mn = mn; e.sc = sc; e.st = st; e.an = a; e.seg = s;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0=1Hz, 1=2Hz, 2=4Hz, 3=500Hz
    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            case (which)
                0:       clk_1hz   = 1'b1;
                1:       clk_2hz   = 1'b1;
                2:       clk_4hz   = 1'b1;
                default: clk_500hz = 1'b1;
            endcase
            tick();
            clk_1hz = 1'b0; clk_2hz = 1'b0; clk_4hz = 1'b0; clk_500hz = 1'b0;
            tick();
        end
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; tick(); btn_pause = 1'b0; tick();
    endtask

    task automatic press_clr();
        btn_clr = 1'b1; tick(); btn_clr = 1'b0; tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        expect_d("reset", 0, 8'h00, 8'h00, 2'b00, 4'b1110, 7'b1000000);
        expect_d("reset", 1, 8'h00, 8'h00, 2'b00, 4'b1110, 7'b1000000);
        tick();

        pulse(0, 61);
        expect_t("count61", 0, 8'h01, 8'h01, 2'b00);
        expect_t("count61", 1, 8'h01, 8'h01, 2'b00);
        pulse(3, 1); expect_d("scan1", 0, 8'h01, 8'h01, 2'b00, 4'b1101, 7'b1000000);
        pulse(3, 1); expect_d("scan2", 0, 8'h01, 8'h01, 2'b00, 4'b1011, 7'b1111001);
        pulse(3, 1); expect_d("scan3", 0, 8'h01, 8'h01, 2'b00, 4'b0111, 7'b1000000);
        pulse(3, 1); expect_d("scan0", 0, 8'h01, 8'h01, 2'b00, 4'b1110, 7'b1111001);
        tick();

        press_clr();
        expect_t("clear", 0, 8'h00, 8'h00, 2'b00);

        sw_adjust = 1'b1; sw_sel = 1'b0; tick();
        pulse(1, 59);
        sw_sel = 1'b1;
        pulse(1, 58);
        expect_t("preload", 0, 8'h59, 8'h58, 2'b10);
        expect_t("preload", 1, 8'h09, 8'h58, 2'b10);
        sw_adjust = 1'b0; tick();
        pulse(0, 1);
        expect_t("to5959", 0, 8'h59, 8'h59, 2'b00);
        expect_t("to0959", 1, 8'h09, 8'h59, 2'b00);
        pulse(0, 1);
        expect_t("wrap59", 0, 8'h00, 8'h00, 2'b00);
        expect_t("wrap9", 1, 8'h00, 8'h00, 2'b00);
        tick();

        press_pause();
        pulse(0, 5);
        expect_t("paused", 0, 8'h00, 8'h00, 2'b01);
        press_pause();
        pulse(0, 1);
        expect_t("resumed", 0, 8'h00, 8'h01, 2'b00);
        btn_pause = 1'b1; tick();
        pulse(0, 3);
        expect_t("held", 0, 8'h00, 8'h01, 2'b01);
        btn_pause = 1'b0; tick();
        press_pause();
        expect_t("rerun", 0, 8'h00, 8'h01, 2'b00);

        pulse(0, 57);
        expect_t("at0058", 0, 8'h00, 8'h58, 2'b00);
        sw_adjust = 1'b1; sw_sel = 1'b1; tick();
        pulse(1, 3);
        expect_t("adj_sec", 0, 8'h00, 8'h01, 2'b10);
        pulse(0, 3);
        expect_t("adj_no1hz", 0, 8'h00, 8'h01, 2'b10);
        expect_t("adj_no1hz", 1, 8'h00, 8'h01, 2'b10);
        pulse(2, 1);
        pulse(3, 2);
        expect_d("blink_i2", 0, 8'h00, 8'h01, 2'b10, 4'b1011, 7'b1000000);
        pulse(3, 2);
        expect_d("blink_i0", 0, 8'h00, 8'h01, 2'b10, 4'b1110, 7'b1111111);
        expect_d("noblink_i0", 1, 8'h00, 8'h01, 2'b10, 4'b1110, 7'b1111001);
        press_pause();
        expect_t("adj_flag", 0, 8'h00, 8'h01, 2'b10);
        sw_adjust = 1'b0; tick();
        expect_t("exit_pause", 0, 8'h00, 8'h01, 2'b01);
        press_pause();
        expect_t("exit_run", 0, 8'h00, 8'h01, 2'b00);

        pulse(0, 196);
        expect_t("at0317", 0, 8'h03, 8'h17, 2'b00);
        btn_clr = 1'b1; clk_1hz = 1'b1; tick();
        btn_clr = 1'b0; clk_1hz = 1'b0;
        expect_t("clr_prio", 0, 8'h00, 8'h00, 2'b00);
        tick();

        pulse(0, 754);
        expect_t("at1234", 0, 8'h12, 8'h34, 2'b00);
        expect_t("at0234", 1, 8'h02, 8'h34, 2'b00);
        pulse(3, 1);
        btn_pause = 1'b1; rst_n = 1'b0; tick();
        rst_n = 1'b1;
        expect_d("midreset", 0, 8'h00, 8'h00, 2'b00, 4'b1110, 7'b1000000);
        tick();
        expect_t("held_rst", 0, 8'h00, 8'h00, 2'b00);
        btn_pause = 1'b0;
        tick(); tick();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
